// File: rtl/axis_matvec_pkg.sv
// Shared width derivations for the tiled AXI-Stream matrix-vector multiplier.
// The top module and its dot-product tile compute port and accumulator
// widths through these functions, so the widths cannot drift apart.
package axis_matvec_pkg;

  // Result width: a full product plus enough headroom for C accumulations.
  function automatic int calc_w_y(input int w_x, input int w_k, input int c);
    return w_x + w_k + $clog2(c);
  endfunction

  // Input beat: R*C_T matrix elements above C_T vector elements.
  function automatic int calc_bus_in_w(input int r, input int c_t,
                                       input int w_k, input int w_x);
    return r * c_t * w_k + c_t * w_x;
  endfunction

  // Output beat: one W_Y result per row.
  function automatic int calc_bus_out_w(input int r, input int w_y);
    return r * w_y;
  endfunction

endpackage

// File: rtl/matvec_tile_dot.sv
// Combinational partial dot products for one input beat.
// For every row r, psum[r] = sum over the C_T columns of the beat of
// k_tile[r][c] * x_tile[c], sign- or zero-extended to W_Y bits.
//   k_tile : R*C_T*W_K  matrix tile, element (r,c) at ((r*C_T)+c)*W_K
//   x_tile : C_T*W_X    vector tile, element c at c*W_X
//   psum   : R*W_Y      per-row partial sums, row r at r*W_Y
module matvec_tile_dot
  import axis_matvec_pkg::*;
#(
  parameter int R      = 8,
  parameter int C_T    = 2,
  parameter int W_X    = 8,
  parameter int W_K    = 8,
  parameter int SIGNED = 1,
  parameter int W_Y    = calc_w_y(W_X, W_K, 8)
) (
  input  logic [R*C_T*W_K-1:0] k_tile,
  input  logic [C_T*W_X-1:0]   x_tile,
  output logic [R*W_Y-1:0]     psum
);

  // One extra operand bit lets a single signed multiplier serve both modes:
  // the extension bit is the sign bit when SIGNED, zero otherwise.
  localparam int   PW = W_X + W_K + 2;
  localparam logic SX = (SIGNED != 0);

  logic signed [W_X:0]   x_ext   [C_T];
  logic signed [W_K:0]   k_ext   [R][C_T];
  logic signed [PW-1:0]  prod    [R][C_T];
  logic signed [W_Y-1:0] row_sum [R];

  for (genvar c = 0; c < C_T; c++) begin : g_x
    assign x_ext[c] = {SX & x_tile[c*W_X + W_X-1], x_tile[c*W_X +: W_X]};
  end

  for (genvar r = 0; r < R; r++) begin : g_row
    for (genvar c = 0; c < C_T; c++) begin : g_col
      assign k_ext[r][c] = {SX & k_tile[(r*C_T+c)*W_K + W_K-1],
                            k_tile[(r*C_T+c)*W_K +: W_K]};
      assign prod[r][c]  = PW'(x_ext[c]) * PW'(k_ext[r][c]);
    end
    assign psum[r*W_Y +: W_Y] = row_sum[r];
  end

  // The true product always fits in W_X+W_K bits, so resizing to W_Y
  // (sign-extend or truncate) keeps the sum exact modulo 2^W_Y.
  always_comb begin
    for (int r = 0; r < R; r++) begin
      // NOTE: every combinational output gets a value before any conditional
      // or accumulating update; otherwise synthesis infers a latch.
      row_sum[r] = '0;
      for (int c = 0; c < C_T; c++) begin
        row_sum[r] = row_sum[r] + W_Y'(prod[r][c]);
      end
    end
  end

endmodule

// File: rtl/axis_matvec_mul_tiled.sv
// Tiled matrix-vector multiplier with AXI-Stream style handshakes.
// A vector arrives as N_T = C/C_T beats, each carrying C_T columns of the
// matrix (all R rows) and of the vector. Per-row accumulators collect the
// beat partial sums; the final beat loads y = K*x into the output register.
//   clk, rstn          : clock, asynchronous active-low reset
//   s_valid/s_ready    : input beat handshake
//   s_data             : {k_tile[R][C_T][W_K], x_tile[C_T][W_X]}
//   m_valid/m_ready    : result handshake
//   m_data             : y[R-1:0][W_Y], row r at r*W_Y
module axis_matvec_mul_tiled
  import axis_matvec_pkg::*;
#(
  parameter  int R         = 8,
  parameter  int C         = 8,
  parameter  int C_T       = 2,
  parameter  int W_X       = 8,
  parameter  int W_K       = 8,
  parameter  int SIGNED    = 1,
  localparam int N_T       = C / C_T,
  localparam int W_Y       = calc_w_y(W_X, W_K, C),
  localparam int BUS_IN_W  = calc_bus_in_w(R, C_T, W_K, W_X),
  localparam int BUS_OUT_W = calc_bus_out_w(R, W_Y)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [BUS_IN_W-1:0]  s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [BUS_OUT_W-1:0] m_data
);

  if (C % C_T != 0) begin : g_bad_tiling
    $error("axis_matvec_mul_tiled: C must be a multiple of C_T");
  end

  localparam int                BEAT_W    = (N_T > 1) ? $clog2(N_T) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_T - 1);

  logic [BEAT_W-1:0] beat;
  logic              run_q;
  logic [W_Y-1:0]    acc      [R];
  logic [W_Y-1:0]    next_acc [R];
  logic [R*W_Y-1:0]  psum;
  logic              is_last;
  logic              in_hs;
  logic              out_hs;

  matvec_tile_dot #(
    .R      (R),
    .C_T    (C_T),
    .W_X    (W_X),
    .W_K    (W_K),
    .SIGNED (SIGNED),
    .W_Y    (W_Y)
  ) u_dot (
    .k_tile (s_data[BUS_IN_W-1 -: R*C_T*W_K]),
    .x_tile (s_data[C_T*W_X-1:0]),
    .psum   (psum)
  );

  // Only the final beat needs room in the output register; earlier beats of
  // the next vector stream into the accumulators while a result is stalled.
  // run_q keeps s_ready low during reset and until the first edge after it.
  assign is_last = (beat == LAST_BEAT);
  assign s_ready = run_q && (!is_last || !m_valid || m_ready);
  assign in_hs   = s_valid && s_ready;
  assign out_hs  = m_valid && m_ready;

  // Beat 0 restarts the sum, which also discards any stale partial vector.
  for (genvar r = 0; r < R; r++) begin : g_next
    assign next_acc[r] = ((beat == '0) ? '0 : acc[r]) + psum[r*W_Y +: W_Y];
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order or process scheduling.
    if (!rstn) begin
      beat  <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (in_hs) beat <= is_last ? '0 : beat + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: register arrays are normally left unreset so they can map to
      // RAM; these few accumulators are plain flops and must read zero.
      for (int r = 0; r < R; r++) acc[r] <= '0;
    end else if (in_hs) begin
      for (int r = 0; r < R; r++) acc[r] <= next_acc[r];
    end
  end

  // A final beat accepted on the same edge as an output handshake simply
  // replaces the result, so m_valid stays high without a bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (in_hs && is_last) begin
      m_valid <= 1'b1;
      for (int r = 0; r < R; r++) m_data[r*W_Y +: W_Y] <= next_acc[r];
    end else if (out_hs) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_matvec_mul_tiled.sv
// Scoreboard bench for axis_matvec_mul_tiled. A signed and an unsigned
// instance share one stimulus stream; each completed vector pushes the
// expected result of a plain-arithmetic model into a per-instance queue,
// and a sink/monitor process pops and compares on every output handshake.
module tb_axis_matvec_mul_tiled;

  localparam int R         = 8;
  localparam int C         = 8;
  localparam int C_T       = 2;
  localparam int W_X       = 8;
  localparam int W_K       = 8;
  localparam int N_T       = C / C_T;
  localparam int W_Y       = W_X + W_K + 3;
  localparam int BUS_IN_W  = R*C_T*W_K + C_T*W_X;
  localparam int BUS_OUT_W = R*W_Y;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 s_valid;
  logic [BUS_IN_W-1:0]  s_data;
  logic                 m_ready;
  logic                 s_ready_s, s_ready_u;
  logic                 m_valid_s, m_valid_u;
  logic [BUS_OUT_W-1:0] m_data_s, m_data_u;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sink_prob  = 100;
  int prob_valid = 100;

  logic [BUS_OUT_W-1:0] exp_s [$];
  logic [BUS_OUT_W-1:0] exp_u [$];
  int k_cur [R][C];
  int x_cur [C];

  axis_matvec_mul_tiled #(.R(R), .C(C), .C_T(C_T), .W_X(W_X), .W_K(W_K), .SIGNED(1)) dut_s (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data),
    .m_valid(m_valid_s), .m_ready(m_ready), .m_data(m_data_s));

  axis_matvec_mul_tiled #(.R(R), .C(C), .C_T(C_T), .W_X(W_X), .W_K(W_K), .SIGNED(0)) dut_u (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready_u), .s_data(s_data),
    .m_valid(m_valid_u), .m_ready(m_ready), .m_data(m_data_u));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic check_vec(input string name, input logic [BUS_OUT_W-1:0] act,
                           input logic [BUS_OUT_W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // y[r] = sum_c k[r][c]*x[c], elements read as 8-bit two's complement or
  // unsigned, result reduced to W_Y bits.
  function automatic logic [BUS_OUT_W-1:0] model(input bit sgn);
    logic [BUS_OUT_W-1:0] y;
    longint sum, kv, xv;
    y = '0;
    for (int r = 0; r < R; r++) begin
      sum = 0;
      for (int c = 0; c < C; c++) begin
        kv = k_cur[r][c];
        xv = x_cur[c];
        if (sgn) begin
          if (kv >= 128) kv -= 256;
          if (xv >= 128) xv -= 256;
        end
        sum += kv * xv;
      end
      y[r*W_Y +: W_Y] = sum[W_Y-1:0];
    end
    return y;
  endfunction

  function automatic logic [BUS_IN_W-1:0] pack_beat(input int b);
    logic [BUS_IN_W-1:0] d;
    d = '0;
    for (int c = 0; c < C_T; c++) begin
      d[c*W_X +: W_X] = W_X'(x_cur[b*C_T + c]);
      for (int r = 0; r < R; r++)
        d[C_T*W_X + (r*C_T + c)*W_K +: W_K] = W_K'(k_cur[r][b*C_T + c]);
    end
    return d;
  endfunction

  task automatic fill(input int kval, input int xval);
    for (int c = 0; c < C; c++) begin
      x_cur[c] = xval;
      for (int r = 0; r < R; r++) k_cur[r][c] = kval;
    end
  endtask

  task automatic fill_random();
    for (int c = 0; c < C; c++) begin
      x_cur[c] = int'($urandom_range(0, 255));
      for (int r = 0; r < R; r++) k_cur[r][c] = int'($urandom_range(0, 255));
    end
  endtask

  // All driving and sampling happens 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_beat(input int b, input bit last);
    int n;
    while ($urandom_range(0, 99) >= prob_valid) tick();
    s_valid = 1'b1;
    s_data  = pack_beat(b);
    n = 0;
    while (!s_ready_s && n < 2000) begin
      tick();
      n++;
    end
    if (!s_ready_s) begin
      check("s_ready_timeout", s_ready_s, 1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (last) begin
      exp_s.push_back(model(1'b1));
      exp_u.push_back(model(1'b0));
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_vector();
    for (int b = 0; b < N_T; b++) send_beat(b, b == N_T - 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_s.size() != 0 || exp_u.size() != 0) && n < 20000) begin
      tick();
      n++;
    end
    check({name, "_left_s"}, exp_s.size(), 0);
    check({name, "_left_u"}, exp_u.size(), 0);
  endtask

  // Sink and monitor: picks m_ready, checks held outputs during stalls and
  // compares every handshaked result against the scoreboard.
  initial begin
    bit prev_stall;
    logic [BUS_OUT_W-1:0] prev_s, prev_u;
    prev_stall = 1'b0;
    prev_s = '0;
    prev_u = '0;
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && prev_stall) begin
        check("hold_valid", m_valid_s, 1);
        check_vec("hold_data_s", m_data_s, prev_s);
        check_vec("hold_data_u", m_data_u, prev_u);
      end
      m_ready = ($urandom_range(0, 99) < sink_prob);
      if (rstn && m_valid_s && m_ready) begin
        if (exp_s.size() == 0) check("unexpected_s", m_valid_s, 0);
        else check_vec("result_s", m_data_s, exp_s.pop_front());
      end
      if (rstn && m_valid_u && m_ready) begin
        if (exp_u.size() == 0) check("unexpected_u", m_valid_u, 0);
        else check_vec("result_u", m_data_u, exp_u.pop_front());
      end
      prev_stall = rstn && m_valid_s && !m_ready;
      prev_s = m_data_s;
      prev_u = m_data_u;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) tick();
    check("rst_s_ready", s_ready_s, 0);
    check("rst_m_valid_s", m_valid_s, 0);
    check("rst_m_valid_u", m_valid_u, 0);
    check_vec("rst_m_data_s", m_data_s, '0);
    rstn = 1'b1;
    repeat (2) tick();

    // All-ones vector: every row sums eight 1*1 products.
    sink_prob = 100;
    fill(1, 1);
    send_vector();
    check("latency_valid", m_valid_s, 1);
    check("ones_y0", m_data_s[W_Y-1:0], 8);

    // Extreme operands in both arithmetic modes.
    fill(8'h80, 8'h80);
    send_vector();
    check("min_y0_signed", m_data_s[W_Y-1:0], 131072);
    check("min_y0_unsigned", m_data_u[W_Y-1:0], 131072);
    fill(8'hFF, 8'hFF);
    send_vector();
    check("max_y0_signed", m_data_s[W_Y-1:0], 8);
    check("max_y0_unsigned", m_data_u[W_Y-1:0], 520200);

    // Back-to-back vectors with both sides always ready: one beat per cycle.
    t0 = cyc;
    repeat (4) begin
      fill_random();
      send_vector();
    end
    check("throughput_cycles", cyc - t0, 4 * N_T);
    drain("burst");

    // Stalled result: the next vector's early beats go in, its last waits.
    sink_prob = 0;
    repeat (2) tick();
    fill_random();
    send_vector();
    fill_random();
    for (int b = 0; b < N_T - 1; b++) send_beat(b, 1'b0);
    s_valid = 1'b1;
    s_data  = pack_beat(N_T - 1);
    check("stall_last_ready", s_ready_s, 0);
    tick();
    check("stall_last_ready2", s_ready_s, 0);
    check("stall_valid", m_valid_s, 1);
    sink_prob = 100;
    tick();
    check("release_ready", s_ready_s, 1);
    @(posedge clk);
    exp_s.push_back(model(1'b1));
    exp_u.push_back(model(1'b0));
    tick();
    s_valid = 1'b0;
    check("release_next_valid", m_valid_s, 1);
    drain("stall");

    // Reset in the middle of a vector discards the partial sums.
    fill_random();
    send_beat(0, 1'b0);
    send_beat(1, 1'b0);
    rstn = 1'b0;
    tick();
    check("midrst_s_ready", s_ready_s, 0);
    check("midrst_m_valid", m_valid_s, 0);
    check_vec("midrst_m_data", m_data_s, '0);
    rstn = 1'b1;
    repeat (2) tick();
    fill(1, 1);
    send_vector();
    check("post_rst_y0", m_data_s[W_Y-1:0], 8);
    drain("reset");

    // Random traffic with sparse valid and sparse ready.
    prob_valid = 10;
    sink_prob  = 10;
    repeat (500) begin
      fill_random();
      send_vector();
    end
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_matvec_mul_tiled.md
AXIS_MATVEC_MUL_TILED -- requirements
Module: axis_matvec_mul_tiled

Interface
REQ-001 Parameter R, default 8, number of matrix rows / output elements.
REQ-002 Parameter C, default 8, number of matrix columns / input vector elements.
REQ-003 Parameter C_T, default 2, columns carried per input beat; C SHALL be an integer multiple of C_T, checked at elaboration.
REQ-004 Parameter W_X, default 8, vector element width.
REQ-005 Parameter W_K, default 8, matrix element width.
REQ-006 Parameter SIGNED, default 1, two's-complement arithmetic when 1, unsigned when 0.
REQ-007 Derived: N_T = C/C_T beats per vector; W_Y = W_X+W_K+$clog2(C); BUS_IN_W = R*C_T*W_K + C_T*W_X; BUS_OUT_W = R*W_Y.
REQ-008 clk  input  1  single clock; all state updates on its rising edge.
REQ-009 rstn  input  1  reset, asynchronous assert, active-low.
REQ-010 s_valid  input  1  input beat valid.
REQ-011 s_ready  output  1  block accepts input beat.
REQ-012 s_data  input  BUS_IN_W  {k_tile[R-1:0][C_T-1:0][W_K], x_tile[C_T-1:0][W_X]}, k in upper bits, x in lower bits; beat b carries columns b*C_T .. b*C_T+C_T-1.
REQ-013 m_valid  output  1  result valid.
REQ-014 m_ready  input  1  downstream accepts result.
REQ-015 m_data  output  BUS_OUT_W  y[R-1:0][W_Y], y[r] = sum over c of k[r][c]*x[c].

Function
REQ-016 Input handshake SHALL occur on a clk edge with s_valid && s_ready; output handshake on m_valid && m_ready.
REQ-017 Beat counter beat SHALL count 0..N_T-1, increment per input handshake, wrap to 0 after N_T-1.
REQ-018 On input handshake, acc[r] SHALL load (beat==0 ? 0 : acc[r]) + sum over the C_T products of the beat, per row, in W_Y bits.
REQ-019 Products and sums SHALL be sign-extended when SIGNED=1, zero-extended when SIGNED=0; no overflow is possible at W_Y.
REQ-020 On handshake of beat N_T-1, final sum SHALL load m_data and set m_valid on the same edge; latency: m_valid high the cycle after the last input handshake.
REQ-021 m_valid SHALL clear on output handshake unless a new final beat is accepted on the same edge, in which case m_data updates and m_valid stays high.
REQ-022 s_ready = (beat != N_T-1) || !m_valid || m_ready: non-final beats of the next vector accepted while a result is stalled; only the final beat waits.
REQ-023 m_data and m_valid SHALL be stable while m_valid && !m_ready.
REQ-024 Sustained throughput SHALL be one beat per cycle with s_valid and m_ready held high.
REQ-025 N_T=1 SHALL degenerate to a one-beat full matvec with one-cycle latency.

Reset
REQ-026 While rstn low: s_ready=0, m_valid=0, m_data=0, beat=0, acc=0.
REQ-027 Reset mid-vector SHALL discard partial accumulation; the next vector after release SHALL start at beat 0.
REQ-028 s_ready SHALL follow REQ-022 from the first edge after rstn deasserts.

Structure
REQ-029 Package axis_matvec_pkg SHALL hold the W_Y and BUS width derivation functions shared with axis_matvec_mul.
REQ-030 Sub-module matvec_tile_dot SHALL compute the R combinational partial sums of one beat, parameterised by R, C_T, W_X, W_K, SIGNED.
REQ-031 Top holds beat counter, accumulators, output register, handshake logic.

Verification (R=8, C=8, C_T=2, W=8)
REQ-032 All k=1, x=1, 4 beats, m_ready=1 -> y[r]=8 for all r, m_valid one cycle after beat 4.
REQ-033 SIGNED=1, all k=0x80, x=0x80 -> y[r]=131072; SIGNED=0, all k=0xFF, x=0xFF -> y[r]=520200.
REQ-034 m_ready=0 after vector A completes; vector B beats 1-3 accepted, beat 4 sees s_ready=0; m_ready=1 -> A handshaked, B beat 4 accepted same edge, B result next cycle.
REQ-035 rstn pulsed low after 2 beats of vector A; then all-ones vector -> y[r]=8, no residue.
REQ-036 500 random vectors, PROB_VALID=10, PROB_READY=10, source/sink with N_BEATS=4 -> every result equals the model, in order.
